// File: rtl/mux4_scan_rx_if.sv
// Bus between the 4:1 mux scanner and its surroundings.
//   ei_n       : active-low enable (high aborts/blocks scanning)
//   start      : request one frame (sampled only when idle)
//   din        : mux output being scanned
//   sel        : mux select driven by the scanner
//   dout       : reassembled 4-bit word, dout[k] = din sampled while sel==k
//   dout_valid : one-cycle strobe when dout is updated
//   busy       : scanner not idle
// The slave modport is the scanner; the master modport is the side that
// drives enable/start/din and consumes the word.
interface mux4_scan_rx_if;
  logic       ei_n;
  logic       start;
  logic       din;
  logic [1:0] sel;
  logic [3:0] dout;
  logic       dout_valid;
  logic       busy;

  modport master (
    output ei_n, start, din,
    input  sel, dout, dout_valid, busy
  );

  modport slave (
    input  ei_n, start, din,
    output sel, dout, dout_valid, busy
  );
endinterface

// File: rtl/mux4_scan_rx.sv
// Receive-side scanner for an HC153-style 4:1 mux. Steps sel through 0..3,
// holds each select for SETTLE cycles, samples din in the following cycle
// and presents the four samples as one word with a one-cycle valid strobe.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : mux4_scan_rx_if.slave (ei_n, start, din in; sel, dout,
//         dout_valid, busy out)
// Parameters:
//   SETTLE : cycles sel is held before the sample cycle (1..15)
//   AUTO   : 1 = rescan continuously, 0 = one frame per start
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start with ei_n low; sel parked at 0
// SETTLE | sel stable, counting SETTLE cycles for the mux to settle
// SAMPLE | capture din into slot sel on the exit edge
module mux4_scan_rx #(
  parameter int unsigned SETTLE = 2,
  parameter bit          AUTO   = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  mux4_scan_rx_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic [3:0] shadow;
  logic [1:0] sel_r;
  logic [3:0] dout_r;
  logic       valid_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      shadow  <= 4'd0;
      sel_r   <= 2'd0;
      dout_r  <= 4'd0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          sel_r <= 2'd0;
          cnt   <= 4'd0;
          if (bus.start && !bus.ei_n) state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (bus.ei_n) begin
            state <= ST_IDLE;
            sel_r <= 2'd0;
            cnt   <= 4'd0;
          end else if (cnt == CNT_LAST) begin
            cnt   <= 4'd0;
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_SAMPLE: begin
          cnt <= 4'd0;
          // Abort wins over the sample that would otherwise land this edge.
          if (bus.ei_n) begin
            state <= ST_IDLE;
            sel_r <= 2'd0;
          end else begin
            shadow[sel_r] <= bus.din;
            if (sel_r != 2'd3) begin
              sel_r <= sel_r + 2'd1;
              state <= ST_SETTLE;
            end else begin
              dout_r  <= {bus.din, shadow[2:0]};
              valid_r <= 1'b1;
              sel_r   <= 2'd0;
              state   <= AUTO ? ST_SETTLE : ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          sel_r <= 2'd0;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign bus.sel        = sel_r;
  assign bus.dout       = dout_r;
  assign bus.dout_valid = valid_r;
  assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_mux4_scan_rx.sv
module tb_mux4_scan_rx;
  logic clk;
  logic rst;
  logic [3:0] in_a;
  logic [3:0] in_b;
  int n_checks;
  int n_fail;

  mux4_scan_rx_if bus_a ();
  mux4_scan_rx_if bus_b ();

  // HC153 models: out = in[sel] while enabled, 0 when ei_n is high
  assign bus_a.din = bus_a.ei_n ? 1'b0 : in_a[bus_a.sel];
  assign bus_b.din = bus_b.ei_n ? 1'b0 : in_b[bus_b.sel];

  mux4_scan_rx #(.SETTLE(2), .AUTO(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  mux4_scan_rx #(.SETTLE(2), .AUTO(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_a();
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
  endtask

  task automatic test_reset();
    #12 rst = 1'b1;
    #1;
    n_checks++; if (bus_a.sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got=%0d exp=0", bus_a.sel); end
    n_checks++; if (bus_a.dout !== 4'd0) begin n_fail++; $display("FAIL reset_dout got=%b exp=0000", bus_a.dout); end
    n_checks++; if (bus_a.dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus_a.dout_valid); end
    n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus_a.busy); end
    n_checks++; if (bus_b.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b got=%b exp=0", bus_b.busy); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [1:0] exp_sel;
    in_a = 4'b1010;
    start_a();
    for (int c = 1; c <= 13; c++) begin
      tick();
      exp_sel = (c >= 12) ? 2'd0 : 2'(c / 3);
      n_checks++; if (bus_a.sel !== exp_sel) begin n_fail++; $display("FAIL frame_sel c=%0d got=%0d exp=%0d", c, bus_a.sel, exp_sel); end
      n_checks++; if (bus_a.dout_valid !== (c == 12)) begin n_fail++; $display("FAIL frame_valid c=%0d got=%b exp=%b", c, bus_a.dout_valid, (c == 12)); end
      n_checks++; if (bus_a.busy !== (c < 12)) begin n_fail++; $display("FAIL frame_busy c=%0d got=%b exp=%b", c, bus_a.busy, (c < 12)); end
      if (c == 12) begin
        n_checks++; if (bus_a.dout !== 4'b1010) begin n_fail++; $display("FAIL frame_dout got=%b exp=1010", bus_a.dout); end
      end
    end
  endtask

  task automatic test_abort();
    in_a = 4'b0110;
    start_a();
    for (int c = 1; c <= 7; c++) tick();
    n_checks++; if (bus_a.sel !== 2'd2) begin n_fail++; $display("FAIL abort_pre_sel got=%0d exp=2", bus_a.sel); end
    bus_a.ei_n = 1'b1;
    tick();
    n_checks++; if (bus_a.sel !== 2'd0) begin n_fail++; $display("FAIL abort_sel got=%0d exp=0", bus_a.sel); end
    n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", bus_a.busy); end
    for (int c = 0; c < 8; c++) begin
      n_checks++; if (bus_a.dout_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid c=%0d got=%b exp=0", c, bus_a.dout_valid); end
      n_checks++; if (bus_a.dout !== 4'b1010) begin n_fail++; $display("FAIL abort_dout c=%0d got=%b exp=1010", c, bus_a.dout); end
      bus_a.start = (c == 3);
      tick();
      n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL abort_blocked_busy c=%0d got=%b exp=0", c, bus_a.busy); end
    end
    bus_a.start = 1'b0;
    bus_a.ei_n = 1'b0;
  endtask

  task automatic test_start_while_busy();
    int nvalid;
    nvalid = 0;
    in_a = 4'b0011;
    start_a();
    for (int c = 1; c <= 30; c++) begin
      bus_a.start = (c == 4 || c == 8);
      tick();
      bus_a.start = 1'b0;
      if (bus_a.dout_valid === 1'b1) begin
        nvalid++;
        n_checks++; if (c != 12) begin n_fail++; $display("FAIL busy_start_valid_cycle got=%0d exp=12", c); end
      end
    end
    n_checks++; if (nvalid != 1) begin n_fail++; $display("FAIL busy_start_nvalid got=%0d exp=1", nvalid); end
    n_checks++; if (bus_a.dout !== 4'b0011) begin n_fail++; $display("FAIL busy_start_dout got=%b exp=0011", bus_a.dout); end
    n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle got=%b exp=0", bus_a.busy); end
  endtask

  task automatic test_auto();
    in_b = 4'b1010;
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      tick();
      n_checks++; if (bus_b.busy !== 1'b1) begin n_fail++; $display("FAIL auto_busy c=%0d got=%b exp=1", c, bus_b.busy); end
      n_checks++; if (bus_b.dout_valid !== (c == 12 || c == 24)) begin n_fail++; $display("FAIL auto_valid c=%0d got=%b exp=%b", c, bus_b.dout_valid, (c == 12 || c == 24)); end
      if (c == 12) begin
        n_checks++; if (bus_b.dout !== 4'b1010) begin n_fail++; $display("FAIL auto_dout1 got=%b exp=1010", bus_b.dout); end
        in_b = 4'b0101;
      end
      if (c == 24) begin
        n_checks++; if (bus_b.dout !== 4'b0101) begin n_fail++; $display("FAIL auto_dout2 got=%b exp=0101", bus_b.dout); end
      end
    end
    bus_b.ei_n = 1'b1;
    tick();
    n_checks++; if (bus_b.busy !== 1'b0) begin n_fail++; $display("FAIL auto_stop_busy got=%b exp=0", bus_b.busy); end
    n_checks++; if (bus_b.dout !== 4'b0101) begin n_fail++; $display("FAIL auto_stop_dout got=%b exp=0101", bus_b.dout); end
    bus_b.ei_n = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    in_a = 4'b1100;
    start_a();
    for (int c = 1; c <= 4; c++) tick();
    n_checks++; if (bus_a.sel !== 2'd1) begin n_fail++; $display("FAIL midrst_pre_sel got=%0d exp=1", bus_a.sel); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus_a.sel !== 2'd0) begin n_fail++; $display("FAIL midrst_sel got=%0d exp=0", bus_a.sel); end
    n_checks++; if (bus_a.dout !== 4'd0) begin n_fail++; $display("FAIL midrst_dout got=%b exp=0000", bus_a.dout); end
    n_checks++; if (bus_a.dout_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b exp=0", bus_a.dout_valid); end
    n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", bus_a.busy); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    in_a = 4'b1001;
    start_a();
    for (int c = 1; c <= 12; c++) begin
      tick();
      n_checks++; if (bus_a.dout_valid !== (c == 12)) begin n_fail++; $display("FAIL midrst_frame_valid c=%0d got=%b exp=%b", c, bus_a.dout_valid, (c == 12)); end
      n_checks++; if (bus_a.busy !== (c < 12)) begin n_fail++; $display("FAIL midrst_frame_busy c=%0d got=%b exp=%b", c, bus_a.busy, (c < 12)); end
    end
    n_checks++; if (bus_a.dout !== 4'b1001) begin n_fail++; $display("FAIL midrst_frame_dout got=%b exp=1001", bus_a.dout); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b0;
    in_a = 4'd0;
    in_b = 4'd0;
    bus_a.ei_n = 1'b0;
    bus_a.start = 1'b0;
    bus_b.ei_n = 1'b0;
    bus_b.start = 1'b0;
    test_reset();
    test_single_frame();
    test_abort();
    test_start_while_busy();
    test_auto();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
